// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-CPU coherence bus controller: bus ops, data-source
// select, controller FSM states and the debug view of the controller.
package common;

    typedef enum logic [1:0] {
        RD  = 2'b00,
        WR  = 2'b01,
        INV = 2'b10,
        NOP = 2'b11
    } bus_op_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        OTHER = 2'd1,
        MEM   = 2'd2
    } datasel_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_WAIT,
        S_INVAL,
        S_DONE
    } bus_state_t;

    typedef struct packed {
        bus_state_t state;
        logic       rr;
        logic       req_idx;
        bus_op_t    op;
        logic [1:0] bstate;
    } dbg_t;

    // Within one CPU a write miss outranks a read miss, which outranks an upgrade.
    function automatic bus_op_t pick_op(input logic wm, input logic rm, input logic inv);
        bus_op_t op;
        op = NOP;
        if (inv) op = INV;
        if (rm)  op = RD;
        if (wm)  op = WR;
        return op;
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_if.sv
// Bus between the coherence controller (master) and the two CPUs (slave).
interface coherence_bus_if;

    logic [1:0]       read_miss;
    logic [1:0]       write_miss;
    logic [1:0]       invalidate;
    logic [1:0][1:0]  block_state;
    logic [1:0][10:0] BICO;
    logic [1:0]       cpu_search_found;
    logic [1:0][15:0] send_other_proc_data;

    logic [1:0]       cpu_search;
    logic [1:0][12:0] BOCI;
    logic [1:0]       grant;
    logic [1:0][1:0]  cpu_datasel;
    logic [1:0]       invalidate_from_other_cpu;
    logic [1:0][15:0] other_proc_data;

    modport master (
        input  read_miss, write_miss, invalidate, block_state, BICO,
               cpu_search_found, send_other_proc_data,
        output cpu_search, BOCI, grant, cpu_datasel,
               invalidate_from_other_cpu, other_proc_data
    );

    modport slave (
        output read_miss, write_miss, invalidate, block_state, BICO,
               cpu_search_found, send_other_proc_data,
        input  cpu_search, BOCI, grant, cpu_datasel,
               invalidate_from_other_cpu, other_proc_data
    );

endinterface

// File: rtl/coherence_bus_ctrl_rr_arbiter.sv
// Two-way round-robin pick with a latched pointer that moves to the
// non-granted CPU whenever a grant is issued.
module rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       advance,
    input  logic       granted,
    output logic       winner,
    output logic       rr
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr <= 1'b0;
        end else if (advance) begin
            rr <= ~granted;
        end
    end

    always_comb begin
        winner = rr;
        if (req == 2'b01) winner = 1'b0;
        if (req == 2'b10) winner = 1'b1;
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-CPU snooping bus controller: arbitrates one miss/upgrade at a time,
// snoops the other CPU, optionally invalidates it, then grants the requester.
module coherence_bus_ctrl
    import common::*;
#(
    parameter int SRCH_LAT = 1,
    parameter int NCPU     = 2
) (
    input  logic            clk,
    input  logic            rst,
    coherence_bus_if.master bus,
    output dbg_t            dbg
);

    // Handshake: a CPU holds read_miss/write_miss/invalidate high until it sees
    // its one-cycle grant; every output is a flop driven from the current state,
    // so each strobe appears one cycle after the state that produces it.

    bus_state_t       state, state_nxt;
    logic [NCPU-1:0]  req_any;
    logic             winner, rr, req_idx, other;
    bus_op_t          op_q;
    logic [10:0]      addr_q;
    logic [1:0]       bstate_q;
    logic [2:0]       cnt;
    logic             found_q, found_now;
    logic [15:0]      data_q, data_now;

    logic [1:0]       search_d, search_q, grant_d, grant_q, inval_d, inval_q;
    logic [1:0][12:0] boci_d, boci_q;
    logic [1:0][1:0]  sel_d, sel_q;
    logic [1:0][15:0] opd_d, opd_q;

    // A CPU whose grant is visible right now is still holding its request.
    assign req_any = (bus.read_miss | bus.write_miss | bus.invalidate) & ~grant_q;
    assign other   = ~req_idx;

    rr_arbiter u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (req_any),
        .advance (state == S_DONE),
        .granted (req_idx),
        .winner  (winner),
        .rr      (rr)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (|req_any) state_nxt = S_SEARCH;
            S_SEARCH: state_nxt = S_WAIT;
            S_WAIT:   if (cnt <= 3'd1) state_nxt = (op_q == RD) ? S_DONE : S_INVAL;
            S_INVAL:  state_nxt = S_DONE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_idx  <= 1'b0;
            op_q     <= NOP;
            addr_q   <= '0;
            bstate_q <= '0;
            cnt      <= '0;
            found_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            if (state == S_IDLE && |req_any) begin
                req_idx  <= winner;
                op_q     <= pick_op(bus.write_miss[winner], bus.read_miss[winner],
                                    bus.invalidate[winner]);
                addr_q   <= bus.BICO[winner];
                bstate_q <= bus.block_state[winner];
            end
            if (state == S_SEARCH)                cnt <= 3'(SRCH_LAT);
            else if (state == S_WAIT && cnt != 0) cnt <= cnt - 3'd1;
            if (state == S_INVAL) begin
                found_q <= bus.cpu_search_found[other];
                data_q  <= bus.send_other_proc_data[other];
            end
        end
    end

    // Reads sample the snoop response while in DONE; writes sampled it in INVAL.
    always_comb begin
        search_d  = '0;
        boci_d    = '0;
        grant_d   = '0;
        inval_d   = '0;
        sel_d     = '0;
        opd_d     = '0;
        found_now = found_q;
        data_now  = data_q;
        if (op_q == RD) begin
            found_now = bus.cpu_search_found[other];
            data_now  = bus.send_other_proc_data[other];
        end
        case (state)
            S_SEARCH: begin
                search_d[other]  = 1'b1;
                boci_d[other]    = {op_q, addr_q};
                boci_d[req_idx]  = {op_q, addr_q};
            end
            S_INVAL:  inval_d[other] = 1'b1;
            S_DONE: begin
                grant_d[req_idx] = 1'b1;
                if (op_q == INV) begin
                    sel_d[req_idx] = NONE;
                end else if (found_now) begin
                    sel_d[req_idx] = OTHER;
                    opd_d[req_idx] = data_now;
                end else begin
                    sel_d[req_idx] = MEM;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            search_q <= '0;
            boci_q   <= '0;
            grant_q  <= '0;
            inval_q  <= '0;
            sel_q    <= '0;
            opd_q    <= '0;
        end else begin
            search_q <= search_d;
            boci_q   <= boci_d;
            grant_q  <= grant_d;
            inval_q  <= inval_d;
            sel_q    <= sel_d;
            opd_q    <= opd_d;
        end
    end

    assign bus.cpu_search                = search_q;
    assign bus.BOCI                      = boci_q;
    assign bus.grant                     = grant_q;
    assign bus.cpu_datasel               = sel_q;
    assign bus.invalidate_from_other_cpu = inval_q;
    assign bus.other_proc_data           = opd_q;

    assign dbg.state   = state;
    assign dbg.rr      = rr;
    assign dbg.req_idx = req_idx;
    assign dbg.op      = op_q;
    assign dbg.bstate  = bstate_q;

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Bench for coherence_bus_ctrl: one instance with SRCH_LAT=1, one with SRCH_LAT=3,
// checked cycle by cycle against a transaction-timeline reference model.
module tb_coherence_bus_ctrl;
  import common::*;

  localparam int W = 68;

  logic clk;
  logic rst;
  int n_cmp;
  int n_fail;
  logic [W-1:0] exp_q[$];

  logic [1:0]       rm_v[2];
  logic [1:0]       wm_v[2];
  logic [1:0]       iv_v[2];
  logic [1:0]       fnd_v[2];
  logic [1:0][1:0]  bs_v[2];
  logic [1:0][10:0] bico_v[2];
  logic [1:0][15:0] spd_v[2];
  dbg_t dbg0;
  dbg_t dbg1;

  coherence_bus_if bus0();
  coherence_bus_if bus1();

  assign bus0.read_miss            = rm_v[0];
  assign bus0.write_miss           = wm_v[0];
  assign bus0.invalidate           = iv_v[0];
  assign bus0.block_state          = bs_v[0];
  assign bus0.BICO                 = bico_v[0];
  assign bus0.cpu_search_found     = fnd_v[0];
  assign bus0.send_other_proc_data = spd_v[0];
  assign bus1.read_miss            = rm_v[1];
  assign bus1.write_miss           = wm_v[1];
  assign bus1.invalidate           = iv_v[1];
  assign bus1.block_state          = bs_v[1];
  assign bus1.BICO                 = bico_v[1];
  assign bus1.cpu_search_found     = fnd_v[1];
  assign bus1.send_other_proc_data = spd_v[1];

  coherence_bus_ctrl #(.SRCH_LAT(1), .NCPU(2)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0),
    .dbg (dbg0)
  );

  coherence_bus_ctrl #(.SRCH_LAT(3), .NCPU(2)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1),
    .dbg (dbg1)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  function automatic int glat_of(input bus_op_t op, input int lat);
    return (op == RD) ? 3 + lat : 4 + lat;
  endfunction

  // Expected output snapshot n edges after the edge that accepted the request.
  function automatic logic [W-1:0] model(input int n, input int cpu, input bus_op_t op,
                                         input logic [10:0] addr, input logic fnd,
                                         input logic [15:0] dat, input int lat);
    logic [1:0] srch, gnt, inv;
    logic [1:0][12:0] boci;
    logic [1:0][1:0] sel;
    logic [1:0][15:0] opd;
    int oth;
    int g;
    srch = '0; gnt = '0; inv = '0; boci = '0; sel = '0; opd = '0;
    oth = 1 - cpu;
    g = glat_of(op, lat);
    if (n == 2) begin
      srch[oth] = 1'b1;
      boci[0] = {op, addr};
      boci[1] = {op, addr};
    end
    if (op != RD && n == g - 1) inv[oth] = 1'b1;
    if (n == g) begin
      gnt[cpu] = 1'b1;
      if (op == INV) sel[cpu] = NONE;
      else if (fnd) begin
        sel[cpu] = OTHER;
        opd[cpu] = dat;
      end else sel[cpu] = MEM;
    end
    return {srch, boci, gnt, sel, inv, opd};
  endfunction

  function automatic logic [W-1:0] get_obs(input int d);
    if (d == 0)
      return {bus0.cpu_search, bus0.BOCI, bus0.grant, bus0.cpu_datasel,
              bus0.invalidate_from_other_cpu, bus0.other_proc_data};
    return {bus1.cpu_search, bus1.BOCI, bus1.grant, bus1.cpu_datasel,
            bus1.invalidate_from_other_cpu, bus1.other_proc_data};
  endfunction

  // scoreboard
  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input int d, input string tag, input int cycles);
    logic [W-1:0] e;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
      check($sformatf("%s_d%0d_c%0d", tag, d, i + 1), get_obs(d), e);
    end
  endtask

  // driver tasks
  task automatic clear_inputs(input int d);
    rm_v[d] = '0; wm_v[d] = '0; iv_v[d] = '0; fnd_v[d] = '0;
    bs_v[d] = '0; bico_v[d] = '0; spd_v[d] = '0;
  endtask

  task automatic drop_req(input int d, input int cpu);
    rm_v[d][cpu] = 1'b0;
    wm_v[d][cpu] = 1'b0;
    iv_v[d][cpu] = 1'b0;
  endtask

  task automatic start_txn(input int d, input int cpu, input bus_op_t op,
                           input logic [10:0] addr, input logic fnd, input logic [15:0] dat);
    int oth;
    int lat;
    oth = 1 - cpu;
    lat = lat_of(d);
    rm_v[d] = '0; wm_v[d] = '0; iv_v[d] = '0;
    // lower-priority op bits are set at random; the highest one must win
    wm_v[d][cpu] = (op == WR);
    rm_v[d][cpu] = (op == RD) || (op == WR && $urandom_range(0, 1) == 1);
    iv_v[d][cpu] = (op == INV) || ($urandom_range(0, 1) == 1);
    bico_v[d][cpu] = addr;
    bico_v[d][oth] = 11'($urandom);
    bs_v[d][cpu] = 2'($urandom);
    fnd_v[d][oth] = fnd;
    spd_v[d][oth] = dat;
    fnd_v[d][cpu] = 1'($urandom);
    spd_v[d][cpu] = 16'($urandom);
    for (int n = 1; n <= glat_of(op, lat); n++)
      exp_q.push_back(model(n, cpu, op, addr, fnd, dat, lat));
  endtask

  task automatic run_txn(input int d, input int cpu, input bus_op_t op,
                         input logic [10:0] addr, input logic fnd, input logic [15:0] dat,
                         input string tag);
    start_txn(d, cpu, op, addr, fnd, dat);
    step(d, tag, glat_of(op, lat_of(d)));
    drop_req(d, cpu);
    step(d, {tag, "_idle"}, 1);
  endtask

  // Both CPUs request a read together; the round-robin order is cpu_a then cpu_b.
  task automatic run_pair(input int cpu_a, input string tag);
    logic [1:0][10:0] a;
    logic [1:0][15:0] dd;
    int cpu_b;
    int g;
    cpu_b = 1 - cpu_a;
    g = glat_of(RD, 1);
    a[0] = 11'($urandom); a[1] = 11'($urandom);
    dd[0] = 16'($urandom); dd[1] = 16'($urandom);
    rm_v[0] = 2'b11; wm_v[0] = '0; iv_v[0] = '0;
    bico_v[0] = a; spd_v[0] = dd; fnd_v[0] = 2'b11;
    exp_q.push_back('0);
    for (int n = 1; n <= g; n++) exp_q.push_back(model(n, cpu_a, RD, a[cpu_a], 1'b1, dd[cpu_b], 1));
    for (int n = 1; n <= g; n++) exp_q.push_back(model(n, cpu_b, RD, a[cpu_b], 1'b1, dd[cpu_a], 1));
    void'(exp_q.pop_front());
    step(0, {tag, "_first"}, g);
    drop_req(0, cpu_a);
    step(0, {tag, "_second"}, g);
    drop_req(0, cpu_b);
    step(0, {tag, "_idle"}, 1);
  endtask

  initial begin
    int d;
    int cpu;
    bus_op_t op;
    n_cmp = 0;
    n_fail = 0;
    clear_inputs(0);
    clear_inputs(1);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs_d0", get_obs(0), '0);
    check("reset_outputs_d1", get_obs(1), '0);
    n_cmp++;
    assert (dbg0.state === S_IDLE && dbg1.state === S_IDLE && dbg0.rr === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_state observed=%0d/%0d rr=%b expected=IDLE/IDLE rr=0",
             dbg0.state, dbg1.state, dbg0.rr);
    end
    rst = 1'b0;

    run_txn(0, 0, RD, 11'h055, 1'b1, 16'hBEEF, "rd_hit_cpu0");
    run_txn(0, 1, WR, 11'h3FF, 1'b0, 16'h1234, "wr_miss_cpu1");
    run_txn(0, 0, INV, 11'h123, 1'b1, 16'hCAFE, "inv_cpu0");

    // round-robin order from a fresh reset
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    clear_inputs(0);
    run_pair(0, "pair1");
    run_pair(0, "pair3");

    // reset while the controller waits for the snoop response
    start_txn(0, 0, RD, 11'h2A5, 1'b1, 16'h5A5A);
    step(0, "abort_pre", 2);
    rst = 1'b1;
    exp_q.delete();
    #1;
    check("abort_async_clear", get_obs(0), '0);
    @(negedge clk);
    check("abort_held_no_grant", get_obs(0), '0);
    rst = 1'b0;
    run_txn(0, 0, RD, 11'h2A5, 1'b1, 16'h5A5A, "abort_reservice");

    run_txn(1, 0, RD, 11'h0F0, 1'b1, 16'h7777, "lat3_rd");
    run_txn(1, 1, WR, 11'h00F, 1'b1, 16'h8888, "lat3_wr");

    for (int i = 0; i < 24; i++) begin
      d = (i % 4 == 3) ? 1 : 0;
      cpu = $urandom_range(0, 1);
      op = bus_op_t'($urandom_range(0, 2));
      run_txn(d, cpu, op, 11'($urandom), 1'($urandom), 16'($urandom), "rand");
      for (int k = 0; k < $urandom_range(0, 2); k++) begin
        exp_q.push_back('0);
        step(d, "rand_gap", 1);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
